// File: rtl/byte_word_packer.sv
// Serial-to-parallel packer: collects B-bit chunks, LSB lane first, into W-bit words
// with valid/ready on both sides and a flush that emits a zero-padded partial word.
module byte_word_packer #(
  parameter int W = 256,
  parameter int B = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [B-1:0]                 in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_data,
  output logic [$clog2(W/B+1)-1:0]     out_lanes
);

  localparam int N  = W / B;
  localparam int LW = $clog2(N + 1);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (W % B != 0) begin : g_width_check
      $error("byte_word_packer: W must be a multiple of B");
    end
  endgenerate

  logic [W-1:0]  acc;
  logic [W-1:0]  acc_wr;
  logic [CW-1:0] cnt;
  logic          flush_pend;
  logic          slot_free;
  logic          last;
  logic          accept;
  logic          full_load;
  logic          flush_load;
  logic          flush_set;

  always_comb begin
    slot_free  = !out_valid || out_ready;
    last       = (cnt == CW'(N - 1));
    in_ready   = !flush_pend && (!last || slot_free);
    accept     = in_valid && in_ready;
    full_load  = accept && last;
    flush_load = flush_pend && slot_free;
    // A flush coinciding with the last-lane accept is just a full word.
    flush_set  = flush && !flush_pend && !full_load && (accept || (cnt != '0));
    acc_wr     = acc;
    acc_wr[int'(cnt)*B +: B] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_lanes  <= '0;
    end else if (full_load) begin
      out_data   <= acc_wr;
      out_lanes  <= LW'(N);
      out_valid  <= 1'b1;
      acc        <= '0;
      cnt        <= '0;
    end else if (flush_load) begin
      out_data   <= acc;
      out_lanes  <= LW'(cnt);
      out_valid  <= 1'b1;
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        acc <= acc_wr;
        cnt <= cnt + CW'(1);
      end
      if (flush_set) flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer: directed scenarios plus random traffic, with a
// chunk-list reference model feeding an expected-word queue checked by a monitor.
module tb_byte_word_packer;

  localparam int W  = 256;
  localparam int B  = 8;
  localparam int N  = W / B;
  localparam int LW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [B-1:0]  in_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [LW-1:0] out_lanes;

  byte_word_packer #(.W(W), .B(B)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lanes(out_lanes)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] d; int lanes; } word_t;
  word_t      expq[$];
  logic [7:0] lst[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ramp(input int base, input int n);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = 8'(base + i);
    return r;
  endfunction

  // Reference model: accepted chunks gather in lst; a word is expected when
  // N chunks have arrived or a flush sees a non-empty list.
  task automatic model_emit();
    word_t w;
    w.d = '0;
    w.lanes = lst.size();
    for (int i = 0; i < lst.size(); i++) w.d[i*8 +: 8] = lst[i];
    expq.push_back(w);
    lst.delete();
  endtask

  initial begin : monitor
    logic         held;
    logic [W-1:0] hd;
    logic [LW-1:0] hl;
    word_t        e;
    held = 1'b0;
    hd = '0;
    hl = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expq.delete();
        lst.delete();
        held = 1'b0;
      end else begin
        if (out_valid) begin
          if (held) begin
            chk("hold_data", out_data, hd);
            chk("hold_lanes", W'(out_lanes), W'(hl));
          end
          if (out_ready) begin
            held = 1'b0;
            if (expq.size() == 0) begin
              chk("unexpected_word", W'(1), W'(0));
            end else begin
              e = expq.pop_front();
              chk("sb_data", out_data, e.d);
              chk("sb_lanes", W'(out_lanes), W'(e.lanes));
            end
          end else begin
            held = 1'b1;
            hd = out_data;
            hl = out_lanes;
          end
        end else begin
          held = 1'b0;
        end
        if (in_valid && in_ready) begin
          lst.push_back(in_data);
          if (lst.size() == N) model_emit();
        end
        if (flush && lst.size() > 0) model_emit();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic f);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    flush = f;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    if (!ok) chk("send_timeout", W'(0), W'(1));
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) chk(nm, W'(0), W'(1));
  endtask

  initial begin : stim
    logic [7:0]   rb[N];
    logic [W-1:0] w2, rexp;
    int sent, nw, acc_k, t0, t1;
    logic drop, any;

    // reset state
    #2;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_data", out_data, W'(0));
    chk("rst_out_lanes", W'(out_lanes), W'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // full word, one cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send(8'(i), 1'b0);
    @(negedge clk);
    chk("full_valid", W'(out_valid), W'(1));
    chk("full_data", out_data, ramp(0, N));
    chk("full_lanes", W'(out_lanes), W'(N));
    step();
    @(negedge clk);
    chk("full_valid_drop", W'(out_valid), W'(0));

    // throughput: 64 chunks back-to-back
    sent = 0; nw = 0; t0 = 0; t1 = 0; drop = 1'b0; w2 = '0;
    for (int c = 0; c < 75; c++) begin
      step();
      in_valid = (sent < 64);
      in_data = 8'(sent);
      @(negedge clk);
      if (in_valid && !in_ready) drop = 1'b1;
      if (in_valid && in_ready) sent++;
      if (out_valid) begin
        if (nw == 0) t0 = c;
        if (nw == 1) begin t1 = c; w2 = out_data; end
        nw++;
      end
    end
    step();
    in_valid = 1'b0;
    chk("tp_no_stall", W'(drop), W'(0));
    chk("tp_words", W'(nw), W'(2));
    chk("tp_spacing", W'(t1 - t0), W'(N));
    chk("tp_word2", w2, ramp(32, N));

    // backpressure
    for (int i = 0; i < N; i++) send(8'(8'h40 + i), 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h60;
    acc_k = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!in_ready) break;
      acc_k++;
      step();
      in_data = 8'(8'h60 + acc_k);
    end
    chk("bp_accepted", W'(acc_k), W'(N - 1));
    chk("bp_held_word", out_data, ramp(8'h40, N));
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_last_accept", W'(in_ready), W'(1));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_word2_valid", W'(out_valid), W'(1));
    chk("bp_word2", out_data, ramp(8'h60, N));

    // partial flush
    step();
    for (int i = 0; i < 5; i++) send(8'(8'hA1 + i), 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_valid("pf_timeout");
    chk("pf_data", out_data, ramp(8'hA1, 5));
    chk("pf_lanes", W'(out_lanes), W'(5));
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    any = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) any = 1'b1;
    end
    chk("flush_empty_ignored", W'(any), W'(0));
    step();
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b1);
    wait_valid("pf2_timeout");
    chk("pf2_lane0", out_data, ramp(8'hB1, 2));
    step();

    // flush colliding with a chunk while the slot is busy
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(8'(8'hC0 + i), 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h77, 1'b1);
    any = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (in_ready) any = 1'b1;
    end
    chk("col_in_ready_low", W'(any), W'(0));
    step();
    out_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("col_valid", W'(out_valid), W'(1));
    chk("col_lanes", W'(out_lanes), W'(3));
    chk("col_data", out_data, W'(24'h772211));
    step();

    // asynchronous reset mid-word with a held output
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(8'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) send(8'($urandom), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", W'(out_valid), W'(0));
    chk("arst_data", out_data, W'(0));
    @(negedge clk);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    rexp = '0;
    for (int i = 0; i < N; i++) begin
      rb[i] = 8'($urandom);
      rexp[i*8 +: 8] = rb[i];
      send(rb[i], 1'b0);
    end
    @(negedge clk);
    chk("arst_clean_valid", W'(out_valid), W'(1));
    chk("arst_clean_word", out_data, rexp);
    chk("arst_clean_lanes", W'(out_lanes), W'(N));
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(19) == 0);
      step();
    end

    // drain
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("drain_expq_empty", W'(expq.size()), W'(0));
    chk("drain_list_empty", W'(lst.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
